// File: rtl/tl_a_pkg.sv
// Shared TileLink A-channel definitions: opcodes, payload struct, size defaults.
package tl_a_pkg;

  localparam int unsigned TL_ADDR_W          = 32;
  localparam int unsigned TL_SRC_W           = 6;
  localparam int unsigned TL_MASK_W          = 8;
  localparam int unsigned TL_DEF_MAX_LG_SIZE = 3;
  localparam int unsigned TL_DEF_MAX_REQ_LG  = 6;

  typedef enum logic [2:0] {
    PUT_FULL    = 3'd0,
    PUT_PARTIAL = 3'd1,
    ARITH       = 3'd2,
    LOGIC       = 3'd3,
    GET         = 3'd4,
    HINT        = 3'd5
  } tl_a_opcode_e;

  typedef struct packed {
    logic [2:0]           opcode;
    logic [2:0]           param;
    logic [2:0]           size;
    logic [TL_SRC_W-1:0]  source;
    logic [TL_ADDR_W-1:0] address;
    logic [TL_MASK_W-1:0] mask;
  } tl_a_bits_t;

  // Low-order address bits that must be zero for a 2^size aligned access.
  function automatic logic [7:0] size_lo_mask(input logic [2:0] size);
    return 8'((9'd1 << size) - 9'd1);
  endfunction

endpackage

// File: rtl/tl_frag_counter.sv
// Fragment/beat counter: tracks the position within a request and flags its last piece.
module tl_frag_counter #(
  parameter int unsigned MAX_LG_SIZE = 3,
  parameter int unsigned FRAG_W      = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              fire_i,
  input  logic              multi_i,
  input  logic [2:0]        size_i,
  output logic [FRAG_W-1:0] cnt_o,
  output logic              last_c_o
);

  logic [FRAG_W-1:0] cnt_q;
  logic [FRAG_W-1:0] cnt_d;
  logic [FRAG_W-1:0] nfrag_m1_c;

  // nfrag-1: all-ones over (size - MAX_LG_SIZE) bits for multi-piece requests.
  always_comb begin
    nfrag_m1_c = '0;
    if (multi_i) begin
      nfrag_m1_c = FRAG_W'((9'd1 << (size_i - 3'(MAX_LG_SIZE))) - 9'd1);
    end
  end

  assign last_c_o = (cnt_q == nfrag_m1_c);

  always_comb begin
    cnt_d = cnt_q;
    if (fire_i) begin
      cnt_d = last_c_o ? '0 : cnt_q + FRAG_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/tl_a_fragment_splitter.sv
// A-channel splitter behind the fragmenter repeater: narrows requests to 2^MAX_LG_SIZE
// bytes, steering replays for Get/Hint and stepping addresses per fragment or beat.
module tl_a_fragment_splitter
  import tl_a_pkg::*;
#(
  parameter  int unsigned ADDR_W      = TL_ADDR_W,
  parameter  int unsigned SRC_W       = TL_SRC_W,
  parameter  int unsigned MAX_LG_SIZE = TL_DEF_MAX_LG_SIZE,
  parameter  int unsigned MAX_REQ_LG  = TL_DEF_MAX_REQ_LG,
  localparam int unsigned FRAG_W      = MAX_REQ_LG - MAX_LG_SIZE
) (
  input  logic              clock,
  input  logic              reset,
  output logic              io_repeat,
  output logic              io_in_ready,
  input  logic              io_in_valid,
  input  logic [2:0]        io_in_bits_opcode,
  input  logic [2:0]        io_in_bits_param,
  input  logic [2:0]        io_in_bits_size,
  input  logic [SRC_W-1:0]  io_in_bits_source,
  input  logic [ADDR_W-1:0] io_in_bits_address,
  input  logic [7:0]        io_in_bits_mask,
  input  logic              io_out_ready,
  output logic              io_out_valid,
  output logic [2:0]        io_out_bits_opcode,
  output logic [2:0]        io_out_bits_param,
  output logic [2:0]        io_out_bits_size,
  output logic [SRC_W-1:0]  io_out_bits_source,
  output logic [ADDR_W-1:0] io_out_bits_address,
  output logic [7:0]        io_out_bits_mask,
  output logic [FRAG_W-1:0] io_out_frag_idx,
  output logic              io_out_frag_last,
  output logic              io_err
);

  logic              large_c;
  logic              split_req_c;
  logic              beat_req_c;
  logic              fire_c;
  logic              last_c;
  logic              misalign_c;
  logic [FRAG_W-1:0] cnt;
  logic              err_q;
  logic              err_d;
  tl_a_bits_t        out_bits_c;

  // Request classification.
  assign large_c     = io_in_bits_size > 3'(MAX_LG_SIZE);
  assign split_req_c = large_c & ((io_in_bits_opcode == GET) |
                                  (io_in_bits_opcode == HINT));
  assign beat_req_c  = large_c & ~io_in_bits_opcode[2];

  assign fire_c      = io_in_valid & io_out_ready;
  assign io_out_valid = io_in_valid;
  assign io_in_ready  = io_out_ready;

  tl_frag_counter #(
    .MAX_LG_SIZE (MAX_LG_SIZE),
    .FRAG_W      (FRAG_W)
  ) u_frag_counter (
    .clk_i    (clock),
    .rst_i    (reset),
    .fire_i   (fire_c),
    .multi_i  (split_req_c | beat_req_c),
    .size_i   (io_in_bits_size),
    .cnt_o    (cnt),
    .last_c_o (last_c)
  );

  assign io_repeat        = split_req_c & ~last_c;
  assign io_out_frag_idx  = cnt;
  assign io_out_frag_last = last_c;

  // Fragment payload; the address OR only steps correctly for size-aligned bases.
  always_comb begin
    out_bits_c         = '0;
    out_bits_c.opcode  = io_in_bits_opcode;
    out_bits_c.param   = io_in_bits_param;
    out_bits_c.size    = large_c ? 3'(MAX_LG_SIZE) : io_in_bits_size;
    out_bits_c.source  = TL_SRC_W'(io_in_bits_source);
    out_bits_c.address = TL_ADDR_W'(io_in_bits_address | (ADDR_W'(cnt) << MAX_LG_SIZE));
    out_bits_c.mask    = io_in_bits_mask;
  end

  assign io_out_bits_opcode  = out_bits_c.opcode;
  assign io_out_bits_param   = out_bits_c.param;
  assign io_out_bits_size    = out_bits_c.size;
  assign io_out_bits_source  = SRC_W'(out_bits_c.source);
  assign io_out_bits_address = ADDR_W'(out_bits_c.address);
  assign io_out_bits_mask    = out_bits_c.mask;

  assign misalign_c = (io_in_bits_address[7:0] & size_lo_mask(io_in_bits_size)) != 8'd0;

  // Sticky misalignment flag, cleared only by reset.
  always_comb begin
    err_d = err_q;
    if (fire_c && misalign_c) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign io_err = err_q;

endmodule

// File: tb/tb_tl_a_fragment_splitter.sv
// Directed bench for tl_a_fragment_splitter: vector table plus multi-cycle corner sequences.
module tb_tl_a_fragment_splitter;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_repeat, io_in_ready, io_in_valid;
  logic [2:0]  io_in_bits_opcode, io_in_bits_param, io_in_bits_size;
  logic [5:0]  io_in_bits_source;
  logic [31:0] io_in_bits_address;
  logic [7:0]  io_in_bits_mask;
  logic        io_out_ready, io_out_valid;
  logic [2:0]  io_out_bits_opcode, io_out_bits_param, io_out_bits_size;
  logic [5:0]  io_out_bits_source;
  logic [31:0] io_out_bits_address;
  logic [7:0]  io_out_bits_mask;
  logic [2:0]  io_out_frag_idx;
  logic        io_out_frag_last, io_err;

  int n_tests = 0;
  int n_fail  = 0;
  int n_fire;

  always #5 clock = ~clock;

  tl_a_fragment_splitter dut (
    .clock(clock), .reset(reset), .io_repeat(io_repeat), .io_in_ready(io_in_ready),
    .io_in_valid(io_in_valid), .io_in_bits_opcode(io_in_bits_opcode),
    .io_in_bits_param(io_in_bits_param), .io_in_bits_size(io_in_bits_size),
    .io_in_bits_source(io_in_bits_source), .io_in_bits_address(io_in_bits_address),
    .io_in_bits_mask(io_in_bits_mask), .io_out_ready(io_out_ready),
    .io_out_valid(io_out_valid), .io_out_bits_opcode(io_out_bits_opcode),
    .io_out_bits_param(io_out_bits_param), .io_out_bits_size(io_out_bits_size),
    .io_out_bits_source(io_out_bits_source), .io_out_bits_address(io_out_bits_address),
    .io_out_bits_mask(io_out_bits_mask), .io_out_frag_idx(io_out_frag_idx),
    .io_out_frag_last(io_out_frag_last), .io_err(io_err)
  );

  typedef struct {
    logic        valid;
    logic [2:0]  op;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [7:0]  mask;
    logic        rdy;
    logic [31:0] e_addr;
    logic [2:0]  e_size;
    logic [2:0]  e_idx;
    logic        e_last;
    logic        e_rep;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [2:0] op, input logic [2:0] sz,
                              input logic [31:0] a, input logic [7:0] m, input logic r,
                              input logic [31:0] ea, input logic [2:0] es, input logic [2:0] ei,
                              input logic el, input logic er, input logic ee);
    vec_t t;
    t.valid = v; t.op = op; t.size = sz; t.addr = a; t.mask = m; t.rdy = r;
    t.e_addr = ea; t.e_size = es; t.e_idx = ei; t.e_last = el; t.e_rep = er; t.e_err = ee;
    return t;
  endfunction

  // Drive inputs just after a rising edge so they settle well before the next one.
  task automatic drive(input logic v, input logic [2:0] op, input logic [2:0] sz,
                       input logic [31:0] a, input logic [7:0] m, input logic r);
    @(posedge clock);
    #1;
    io_in_valid = v; io_in_bits_opcode = op; io_in_bits_size = sz;
    io_in_bits_address = a; io_in_bits_mask = m; io_out_ready = r;
    @(negedge clock);
    if (v && r) n_fire++;
  endtask

  initial begin
    // Idle, single Get, 8-fragment Get, 4-beat PutFull, single Hint, idle.
    vecs.push_back(mk(0, 3'd0, 3'd0, 32'h0, 8'h00, 1, 32'h0, 3'd0, 3'd0, 1, 0, 0));
    vecs.push_back(mk(1, 3'd4, 3'd2, 32'h1004, 8'h0F, 1, 32'h1004, 3'd2, 3'd0, 1, 0, 0));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1, 3'd4, 3'd6, 32'h8000_0040, 8'hFF, 1, 32'h8000_0040 + 32'(8 * i),
                        3'd3, 3'(i), i == 7, i != 7, 0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1, 3'd0, 3'd5, 32'h200, 8'hFF, 1, 32'h200 + 32'(8 * i),
                        3'd3, 3'(i), i == 3, 0, 0));
    vecs.push_back(mk(1, 3'd5, 3'd3, 32'h300, 8'hAA, 1, 32'h300, 3'd3, 3'd0, 1, 0, 0));
    vecs.push_back(mk(0, 3'd4, 3'd6, 32'h0, 8'h00, 1, 32'h0, 3'd3, 3'd0, 0, 1, 0));

    io_in_bits_param = 3'd1;
    io_in_bits_source = 6'h2A;
    io_in_valid = 0; io_in_bits_opcode = 0; io_in_bits_size = 0;
    io_in_bits_address = 0; io_in_bits_mask = 0; io_out_ready = 1;
    reset = 1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_err", 32'(io_err), 32'd0);
    check("reset_out_valid", 32'(io_out_valid), 32'd0);
    check("reset_idx", 32'(io_out_frag_idx), 32'd0);
    @(posedge clock);
    #1 reset = 0;

    foreach (vecs[k]) begin
      drive(vecs[k].valid, vecs[k].op, vecs[k].size, vecs[k].addr, vecs[k].mask, vecs[k].rdy);
      check($sformatf("v%0d_out_valid", k), 32'(io_out_valid), 32'(vecs[k].valid));
      check($sformatf("v%0d_in_ready", k), 32'(io_in_ready), 32'(vecs[k].rdy));
      check($sformatf("v%0d_idx", k), 32'(io_out_frag_idx), 32'(vecs[k].e_idx));
      check($sformatf("v%0d_last", k), 32'(io_out_frag_last), 32'(vecs[k].e_last));
      check($sformatf("v%0d_repeat", k), 32'(io_repeat), 32'(vecs[k].e_rep));
      check($sformatf("v%0d_err", k), 32'(io_err), 32'(vecs[k].e_err));
      if (vecs[k].valid) begin
        check($sformatf("v%0d_addr", k), io_out_bits_address, vecs[k].e_addr);
        check($sformatf("v%0d_size", k), 32'(io_out_bits_size), 32'(vecs[k].e_size));
        check($sformatf("v%0d_opcode", k), 32'(io_out_bits_opcode), 32'(vecs[k].op));
        check($sformatf("v%0d_mask", k), 32'(io_out_bits_mask), 32'(vecs[k].mask));
        check($sformatf("v%0d_param", k), 32'(io_out_bits_param), 32'd1);
        check($sformatf("v%0d_source", k), 32'(io_out_bits_source), 32'h2A);
      end
    end

    // Back-pressure: ready pattern 1,0,0,1 on a 2-fragment Get.
    n_fire = 0;
    drive(1, 3'd4, 3'd4, 32'h2000, 8'hFF, 1);
    check("stall_c0_addr", io_out_bits_address, 32'h2000);
    check("stall_c0_rep", 32'(io_repeat), 32'd1);
    for (int c = 1; c < 3; c++) begin
      drive(1, 3'd4, 3'd4, 32'h2000, 8'hFF, 0);
      check($sformatf("stall_c%0d_addr", c), io_out_bits_address, 32'h2008);
      check($sformatf("stall_c%0d_idx", c), 32'(io_out_frag_idx), 32'd1);
      check($sformatf("stall_c%0d_in_ready", c), 32'(io_in_ready), 32'd0);
    end
    drive(1, 3'd4, 3'd4, 32'h2000, 8'hFF, 1);
    check("stall_c3_addr", io_out_bits_address, 32'h2008);
    check("stall_c3_last", 32'(io_out_frag_last), 32'd1);
    check("stall_c3_rep", 32'(io_repeat), 32'd0);
    drive(0, 3'd4, 3'd4, 32'h2000, 8'hFF, 1);
    check("stall_fires", 32'(n_fire), 32'd2);
    check("stall_idx_wrap", 32'(io_out_frag_idx), 32'd0);
    check("stall_err", 32'(io_err), 32'd0);

    // Misaligned Get: err sets after first fire and sticks; transfer completes.
    drive(1, 3'd4, 3'd4, 32'h1004, 8'hFF, 1);
    check("mis_err_before", 32'(io_err), 32'd0);
    check("mis_addr0", io_out_bits_address, 32'h1004);
    drive(1, 3'd4, 3'd4, 32'h1004, 8'hFF, 1);
    check("mis_err_after1", 32'(io_err), 32'd1);
    check("mis_addr1", io_out_bits_address, 32'h100C);
    check("mis_last1", 32'(io_out_frag_last), 32'd1);
    repeat (3) drive(0, 3'd0, 3'd0, 32'h0, 8'h00, 1);
    check("mis_err_sticky", 32'(io_err), 32'd1);
    check("mis_idx_done", 32'(io_out_frag_idx), 32'd0);

    // Reset after fragment 3 of a 64 B Get, then a fresh single-fragment Get.
    for (int i = 0; i < 4; i++) drive(1, 3'd4, 3'd6, 32'h40, 8'hFF, 1);
    check("rst_pre_idx", 32'(io_out_frag_idx), 32'd3);
    @(posedge clock);
    #1;
    io_in_valid = 0;
    reset = 1;
    @(posedge clock);
    #1 reset = 0;
    @(negedge clock);
    check("rst_mid_idx", 32'(io_out_frag_idx), 32'd0);
    check("rst_mid_err", 32'(io_err), 32'd0);
    check("rst_mid_rep", 32'(io_repeat), 32'd1);
    drive(1, 3'd4, 3'd3, 32'h500, 8'hFF, 1);
    check("rst_new_idx", 32'(io_out_frag_idx), 32'd0);
    check("rst_new_last", 32'(io_out_frag_last), 32'd1);
    check("rst_new_rep", 32'(io_repeat), 32'd0);
    check("rst_new_size", 32'(io_out_bits_size), 32'd3);
    check("rst_new_addr", io_out_bits_address, 32'h500);
    drive(0, 3'd4, 3'd3, 32'h500, 8'hFF, 1);
    check("rst_new_idx_after", 32'(io_out_frag_idx), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
